// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Holds the RX state encoding, the default clock/baud settings, and the
// clocks-per-bit rounding helper. Keeping the defaults here means TX and
// RX always derive the same bit period.
package uart_pkg;

  localparam int CLK_HZ = 16000000;
  localparam int BAUD   = 115200;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_STOP      = ST_STOP,
    S_WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_e;

  // Nearest-integer bit period: 16 MHz / 115200 -> 139.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   i_clk    - destination clock
//   i_reset  - asynchronous active-high reset, loads RESET_VAL into both flops
//   i_async  - asynchronous input
//   o_sync   - input re-timed to i_clk, two cycles of latency
// RESET_VAL lets idle-high lines (UART RX) come out of reset looking idle.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with mid-bit sampling.
// Ports:
//   i_clk        - system clock, rising edge
//   i_reset      - asynchronous active-high reset
//   i_uart_rx    - asynchronous serial line, idle high
//   o_data       - last correctly framed byte, held until the next good byte
//   o_valid      - one-cycle strobe, o_data updated this cycle
//   o_frame_err  - one-cycle strobe, stop bit sampled low
//   o_busy       - high whenever the receiver is not idle
// CLKS_PER_BIT must be at least 4.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic rx_s;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_uart_rx),
    .o_sync  (rx_s)
  );

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q,  data_d;
  logic          valid_q, valid_d;
  logic          ferr_q,  ferr_d;
  logic          busy_q,  busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // Half a bit in: the line must still be low, otherwise it was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        // Counting a full bit from the start-bit midpoint lands mid data bit.
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // Absorb a held-low line (break) so it reports only one frame error.
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a 16-clock-per-bit instance for the
// directed and random scenarios and a 139-clock-per-bit instance for the
// loopback message. Expected bytes and strobe times come from the framing
// rules: 2 cycles of synchronizer latency, half a bit to the start-bit
// midpoint, nine bit periods to the stop-bit midpoint, one registered cycle.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB    = 16;
  localparam int CPB_LB = clks_per_bit(CLK_HZ, BAUD);
  localparam int LAT    = 2 + CPB / 2 + 9 * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx16 = 1'b1;
  logic rx139 = 1'b1;

  logic [7:0] d16, d139;
  logic       v16, v139, fe16, fe139, b16, b139;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_dut16 (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_uart_rx   (rx16),
    .o_data      (d16),
    .o_valid     (v16),
    .o_frame_err (fe16),
    .o_busy      (b16)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_LB)) u_dut139 (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_uart_rx   (rx139),
    .o_data      (d139),
    .o_valid     (v139),
    .o_frame_err (fe139),
    .o_busy      (b139)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled on the falling edge.
  logic [7:0] vq16[$];
  int         vt16[$];
  logic       vbusy16[$];
  logic [7:0] fed16[$];
  int         rise16[$];
  logic [7:0] vq139[$];
  int         fe16_n = 0;
  int         fe139_n = 0;
  int         busy_n = 0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (v16) begin
      vq16.push_back(d16);
      vt16.push_back(cyc);
      vbusy16.push_back(b16);
    end
    if (fe16) begin
      fe16_n <= fe16_n + 1;
      fed16.push_back(d16);
    end
    if (b16) busy_n <= busy_n + 1;
    if (b16 && !busy_prev) rise16.push_back(cyc);
    busy_prev <= b16;
    if (v139) vq139.push_back(d139);
    if (fe139) fe139_n <= fe139_n + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Snapshot markers so each scenario only looks at its own events.
  int vb, feb, fdb, bb, rb, vb139, feb139;
  task automatic mark();
    vb     = vq16.size();
    feb    = fe16_n;
    fdb    = fed16.size();
    bb     = busy_n;
    rb     = rise16.size();
    vb139  = vq139.size();
    feb139 = fe139_n;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bench-side transmitter: 8N1, LSB first, exact bit period.
  task automatic send(input logic sel, input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (sel) rx139 = f[i];
      else     rx16  = f[i];
      repeat (sel ? CPB_LB : CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  {24'h0, d16}, 32'h0);
    check({tag, "_valid"}, {31'h0, v16}, 32'h0);
    check({tag, "_ferr"},  {31'h0, fe16}, 32'h0);
    check({tag, "_busy"},  {31'h0, b16}, 32'h0);
  endtask

  int         st;
  int         g;
  logic [7:0] rb_byte;
  logic [7:0] exp_b[$];
  int         exp_t[$];
  string      msg;

  initial begin
    rst = 1'b1;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(5);

    // Single byte with exact latency and busy timing.
    mark();
    st = cyc;
    send(1'b0, 8'h48, 1'b1);
    idle(20);
    check("single_n", vq16.size() - vb, 1);
    check("single_data", {24'h0, vq16[vb]}, 32'h48);
    check("single_time", vt16[vb] - st, LAT);
    check("single_ferr", fe16_n - feb, 0);
    check("single_busy_rise", rise16[rb] - st, 3);
    check("single_busy_at_valid", {31'h0, vbusy16[vb]}, 32'h0);
    check("single_data_held", {24'h0, d16}, 32'h48);

    // Back-to-back "He".
    mark();
    send(1'b0, 8'h48, 1'b1);
    send(1'b0, 8'h65, 1'b1);
    idle(20);
    check("b2b_n", vq16.size() - vb, 2);
    check("b2b_data0", {24'h0, vq16[vb]}, 32'h48);
    check("b2b_data1", {24'h0, vq16[vb+1]}, 32'h65);
    check("b2b_spacing", vt16[vb+1] - vt16[vb], 10 * CPB);

    // Glitch shorter than half a bit.
    mark();
    g = $urandom_range(1, 6);
    rx16 = 1'b0;
    idle(g);
    rx16 = 1'b1;
    idle(40);
    check("glitch_valid", vq16.size() - vb, 0);
    check("glitch_ferr", fe16_n - feb, 0);
    check("glitch_busy_le9", (busy_n - bb) <= 9, 1);
    check("glitch_busy_seen", (busy_n - bb) > 0, 1);

    // Framing error followed by a break, then a good byte.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    mark();
    send(1'b0, 8'h55, 1'b0);
    idle(100);
    rx16 = 1'b1;
    idle(20);
    check("ferr_n", fe16_n - feb, 1);
    check("ferr_data_kept", {24'h0, fed16[fdb]}, 32'h0);
    check("ferr_no_valid", vq16.size() - vb, 0);
    send(1'b0, 8'hA3, 1'b1);
    idle(20);
    check("ferr_next_n", vq16.size() - vb, 1);
    check("ferr_next_data", {24'h0, vq16[vb]}, 32'hA3);
    check("ferr_next_noerr", fe16_n - feb, 1);

    // Reset in the middle of data bit 4 of 0xFF.
    mark();
    rx16 = 1'b0;
    idle(CPB);
    rx16 = 1'b1;
    idle(4 * CPB + CPB / 2);
    rst = 1'b1;
    #2;
    check_reset_outputs("rst_mid");
    idle(3);
    check_reset_outputs("rst_held");
    rst = 1'b0;
    idle(6 * CPB);
    check("rst_mid_valid", vq16.size() - vb, 0);
    check("rst_mid_ferr", fe16_n - feb, 0);
    send(1'b0, 8'h0F, 1'b1);
    idle(20);
    check("rst_next_n", vq16.size() - vb, 1);
    check("rst_next_data", {24'h0, vq16[vb]}, 32'h0F);

    // Random bytes with random idle gaps (including zero).
    mark();
    for (int i = 0; i < 10; i++) begin
      g = $urandom_range(0, 20);
      if (g > 0) idle(g);
      rb_byte = 8'($urandom);
      exp_b.push_back(rb_byte);
      exp_t.push_back(cyc);
      send(1'b0, rb_byte, 1'b1);
    end
    idle(20);
    check("rand_n", vq16.size() - vb, exp_b.size());
    check("rand_ferr", fe16_n - feb, 0);
    for (int i = 0; i < exp_b.size(); i++) begin
      check($sformatf("rand_data%0d", i), {24'h0, vq16[vb+i]}, {24'h0, exp_b[i]});
      check($sformatf("rand_time%0d", i), vt16[vb+i] - exp_t[i], LAT);
    end

    // Loopback message at the production bit period.
    mark();
    msg = "Hello, world! ";
    for (int i = 0; i < msg.len(); i++) send(1'b1, msg[i], 1'b1);
    idle(20);
    check("lb_n", vq139.size() - vb139, msg.len());
    check("lb_ferr", fe139_n - feb139, 0);
    for (int i = 0; i < msg.len(); i++)
      check($sformatf("lb_char%0d", i), {24'h0, vq139[vb139+i]}, {24'h0, msg[i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver sitting directly downstream of the board's UART transmitter: it consumes the 8N1, LSB-first serial line the transmitter drives and delivers each received byte as a parallel word with a one-cycle strobe. It is used both on the board's RX pin and in loopback against the transmitter for self-test. Framing is fixed:
- idle high, one start bit (low), 8 data bits, one stop bit (high);
- mid-bit sampling driven by an integer clocks-per-bit counter.

## Interface
- CLKS_PER_BIT, default 139 — i_clk cycles per bit (16 MHz / 115200 rounded); must be ≥ 4.
- i_clk  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_uart_rx  input  1  asynchronous serial line, idle high.
- o_data  output  8  last correctly framed byte; held until the next good byte.
- o_valid  output  1  one-cycle strobe: o_data was updated this cycle.
- o_frame_err  output  1  one-cycle strobe: stop bit sampled low.
- o_busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizer.** i_uart_rx passes through a 2-flop synchronizer; both flops reset to 1 so a low line at reset release is not mistaken for an in-progress frame. All decisions below use the synchronized value rx_s.
- **Constants.** HALF = CLKS_PER_BIT/2 (integer division). The counter is wide enough to hold CLKS_PER_BIT−1 and clears on every state transition.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE.** When rx_s==0, go to START.
- **START.** At count == HALF−1, re-sample rx_s:
  - 0: go to DATA with bit index 0.
  - 1: treat as a glitch and return to IDLE; no strobe.
- **DATA.** At count == CLKS_PER_BIT−1, write rx_s into shift[index] (LSB first).
  - After index 7, go to STOP.
  - Otherwise increment index.
- **STOP.** At count == CLKS_PER_BIT−1, sample rx_s:
  - 1: o_data ← shift, o_valid = 1, go to IDLE.
  - 0: o_frame_err = 1, o_data unchanged, go to WAIT_IDLE.
- **WAIT_IDLE.** Stay until rx_s==1, then go to IDLE. A line held low (break) produces exactly one o_frame_err.
- **Reset values:** o_data = 8'h00, o_valid = 0, o_frame_err = 0, o_busy = 0, state IDLE, counter 0, index 0, shift 0. Reset mid-frame abandons the frame with no strobe.
- **No back-pressure.** A byte not consumed before the next o_valid is overwritten.

## Timing
- Cycle T = first cycle rx_s reads 0 in IDLE; START is entered at T+1.
- Start bit confirmed at T+HALF.
- Data bit k sampled at T+HALF+(k+1)·CLKS_PER_BIT.
- Stop bit sampled at T+HALF+9·CLKS_PER_BIT. o_valid or o_frame_err is registered on that edge, so it is high for the single following cycle.
- Pin-to-rx_s latency: 2 cycles.
- o_busy rises at T+1 and falls on the same edge that raises o_valid.
- Back-to-back frames: a start edge arriving immediately after the stop-bit sample is accepted. The FSM is in IDLE from the cycle o_valid is high, so no idle gap beyond the stop bit is required.
- Tolerance: sampling lands mid-bit within ±HALF cycles accumulated drift over 9.5 bits; the ~0.1% rounding error at 115200 baud is well inside this.

## Structure
- Shared package uart_pkg holds:
  - the state encoding, as localparams;
  - a clks_per_bit(clk_hz, baud) rounding function;
  - the default CLK_HZ = 16000000 and BAUD = 115200, so the TX and RX baud settings come from one place.
- One sub-module, uart_rx_sync: a 2-flop synchronizer with a reset value parameter (default 1). It is reused for other asynchronous pins.

## Test plan
All scenarios use CLKS_PER_BIT = 16 (HALF = 8) unless noted.
- **Single byte.** Frame 0x48 ('H') at the exact bit period -> one o_valid pulse with o_data = 8'h48 at T+8+9·16+1; o_frame_err never asserted.
- **Back-to-back bytes.** "He" (0x48, 0x65) with a single stop bit between them -> two o_valid pulses exactly 10·16 cycles apart; o_data = 8'h48 then 8'h65.
- **Glitch rejection.** Line low for 5 cycles, then high -> FSM returns to IDLE; no o_valid or o_frame_err; o_busy high for ≤ 9 cycles.
- **Framing error.** Byte 0x55 with the stop bit low, line held low for 100 cycles, then high, then a good 0xA3 -> one o_frame_err pulse, o_data stays 8'h00; then o_valid with o_data = 8'hA3.
- **Reset mid-frame.** Assert i_reset during data bit 4 of 0xFF, release, then send 0x0F -> no strobe for the aborted frame; the next o_valid carries 8'h0F; all outputs read reset values during reset.
- **Loopback.** CLKS_PER_BIT = 139 driven from the transmitter at 16 MHz for "Hello, world! " -> 14 o_valid pulses with the correct ASCII sequence and zero frame errors.
